mmio_router: RTL
================

Name: mmio_router

Overview:
- Registered, parametrised MMIO router between the rv32 core memory port and NUM_SLAVES peripherals (BRAM, seven-segment register, future devices).
- Decodes each request against a per-slave base/mask window.
- Forwards the valid/ready handshake to the selected slave and muxes read data back.
- Closes every transaction, including unmapped or hung accesses, with a defined error response, so the core can never deadlock on a bad address.

Parameters:
- NUM_SLAVES, 2: number of slave channels, 1..8.
- SLAVE_BASE, {32'hFFFFFFFC, 32'h00000000}: packed NUM_SLAVES*32; slave i base at bits [32*i +: 32].
- SLAVE_MASK, {32'hFFFFFFFC, 32'hFFFF0000}: packed NUM_SLAVES*32; slave i hits when (addr & mask_i) == base_i.
- TIMEOUT_CYCLES, 256: maximum cycles a slave may hold valid without ready; 0 disables the timeout.
- DEFAULT_RDATA, 32'hDEADBEEF: rdata returned on any error completion.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- rv32_valid  in  1  core request valid; held high until rv32_ready is seen.
- rv32_ready  out  1  one-cycle completion pulse to the core.
- rv32_addr  in  32  request address; stable while rv32_valid is high.
- rv32_rdata  out  32  read data; valid while rv32_ready is high.
- slv_valid  out  NUM_SLAVES  per-slave request valid; one-hot or zero.
- slv_ready  in  NUM_SLAVES  per-slave completion.
- slv_rdata  in  NUM_SLAVES*32  per-slave read data, packed like SLAVE_BASE.
- err_valid  out  1  one-cycle pulse coincident with an error completion.
- err_code  out  2  error code: 01 unmapped, 10 timeout; 00 otherwise.
- err_addr  out  32  address of the last errored request; holds until the next error.

Behaviour:
- Reset: asynchronous, active-low; state goes to IDLE. rv32_ready=0, rv32_rdata=0, slv_valid=0, err_valid=0, err_code=0, err_addr=0, timeout counter=0, sel=0.
- Asserting resetn low mid-transaction aborts the transaction with no response. The core is reset by the same signal.
- Decode: combinational on rv32_addr. On overlapping windows the lowest index wins.
- State IDLE:
  - On rv32_valid, latch the address and the decoded index `sel`.
  - Hit: go to ACTIVE, clear the timeout counter.
  - Miss: go to RESP with error=unmapped.
- State ACTIVE:
  - slv_valid[sel]=1; all other bits 0. slv_valid is decoded from registered state, so it is glitch-free.
  - slv_ready[sel]=1: latch slv_rdata[sel] into rv32_rdata, go to RESP with no error.
  - Otherwise, with TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: latch DEFAULT_RDATA, go to RESP with error=timeout.
  - Otherwise increment the counter.
  - If ready and the timeout hit land in the same cycle, ready wins and no error is raised.
  - slv_ready bits other than sel are ignored.
- State RESP:
  - rv32_ready=1 for exactly one cycle; slv_valid=0.
  - If the entry carried an error: err_valid=1, err_code set, err_addr updated.
  - Always returns to IDLE.
- Latency:
  - Hit: rv32_ready rises 2 cycles after rv32_valid is first sampled, plus the slave wait cycles.
  - Unmapped: rv32_ready rises 1 cycle after rv32_valid is first sampled.
  - Timeout: slv_valid is high for exactly TIMEOUT_CYCLES cycles.
- Back-to-back: a new rv32_valid sampled in IDLE the cycle after RESP starts a new transaction. There is no bubble requirement beyond that.
- rv32_valid dropping mid-transaction is a protocol violation: ignored, the transaction still completes.
- rv32_rdata holds its value after RESP until the next completion.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. It never wraps, because the transition out of ACTIVE precedes overflow.
- States are binary-encoded, 2 bits; the unused encoding returns to IDLE.

Decomposition:
- Package mmio_pkg holds:
  - state encodings (IDLE, ACTIVE, RESP);
  - err_code constants (ERR_NONE=2'b00, ERR_UNMAPPED=2'b01, ERR_TIMEOUT=2'b10);
  - the 32-bit data/address width constant.
- One sub-module, mmio_decode: purely combinational. Inputs are the address plus SLAVE_BASE/SLAVE_MASK; outputs are the hit flag and the lowest-index sel ($clog2(NUM_SLAVES) bits, minimum 1).

Test Plan:
- Default parameters; read 0x00000010, slave 0 ready after 3 wait cycles with rdata 0x12345678 -> slv_valid=2'b01 for 4 cycles; rv32_ready pulse 1 cycle later with rv32_rdata=0x12345678; err_valid stays 0.
- Read 0xFFFFFFFC, slave 1 ready the same cycle slv_valid rises, rdata 0x000000A5 -> rv32_ready exactly 2 cycles after the request, rdata 0x000000A5.
- Read 0x00020000 (unmapped) -> slv_valid stays 0; rv32_ready + err_valid 1 cycle after the request; err_code=01, err_addr=0x00020000, rdata=0xDEADBEEF.
- TIMEOUT_CYCLES=4, slave 0 never ready -> slv_valid[0] high exactly 4 cycles; then rv32_ready, err_code=10, rdata=0xDEADBEEF.
- TIMEOUT_CYCLES=4, slave ready on the 4th ACTIVE cycle -> normal completion, no err_valid.
- resetn low during ACTIVE -> all outputs 0 asynchronously; after release, a new read of 0x00000000 completes normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared encodings for the MMIO router: FSM states, error codes, bus width.
package mmio_pkg;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    RESP   = 2'b10
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
endpackage

// File: rtl/mmio_decode.sv
// Address window decoder: reports a hit and the lowest matching slave index.
module mmio_decode
  import mmio_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int SW         = 1
) (
  input  logic [DW-1:0]            addr,
  input  logic [NUM_SLAVES*DW-1:0] base,
  input  logic [NUM_SLAVES*DW-1:0] mask,
  output logic                     hit,
  output logic [SW-1:0]            sel
);
  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & mask[i*DW +: DW]) == base[i*DW +: DW]) begin
        hit = 1'b1;
        sel = SW'(i);
      end
    end
  end
endmodule

// File: rtl/mmio_router.sv
// Registered MMIO router: decodes the core request, forwards it to one slave,
// and closes every transaction, including unmapped and hung ones.
module mmio_router
  import mmio_pkg::*;
#(
  parameter int                     NUM_SLAVES     = 2,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE   = {32'hFFFFFFFC, 32'h00000000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK   = {32'hFFFFFFFC, 32'hFFFF0000},
  parameter int                     TIMEOUT_CYCLES = 256,
  parameter logic [31:0]            DEFAULT_RDATA  = 32'hDEADBEEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     rv32_valid,
  output logic                     rv32_ready,
  input  logic [DW-1:0]            rv32_addr,
  output logic [DW-1:0]            rv32_rdata,
  output logic [NUM_SLAVES-1:0]    slv_valid,
  input  logic [NUM_SLAVES-1:0]    slv_ready,
  input  logic [NUM_SLAVES*DW-1:0] slv_rdata,
  output logic                     err_valid,
  output logic [1:0]               err_code,
  output logic [DW-1:0]            err_addr
);
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t                          state, state_d;
  logic   [SW-1:0]                 sel_q, dec_sel;
  logic                            dec_hit;
  logic   [DW-1:0]                 addr_q;
  logic   [CW-1:0]                 cnt;
  logic   [1:0]                    pend_err;
  logic   [NUM_SLAVES-1:0][DW-1:0] rdata_arr;
  logic                            ld_req, miss, inc_cnt, cpl_ok, cpl_to;

  assign rdata_arr = slv_rdata;

  mmio_decode #(.NUM_SLAVES(NUM_SLAVES), .SW(SW)) u_decode (
    .addr (rv32_addr),
    .base (SLAVE_BASE),
    .mask (SLAVE_MASK),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // A slave ready in the timeout cycle wins because it is tested first.
  always_comb begin
    state_d = state;
    ld_req  = 1'b0;
    miss    = 1'b0;
    inc_cnt = 1'b0;
    cpl_ok  = 1'b0;
    cpl_to  = 1'b0;
    case (state)
      IDLE: if (rv32_valid) begin
        ld_req = 1'b1;
        if (dec_hit) state_d = ACTIVE;
        else begin
          miss    = 1'b1;
          state_d = RESP;
        end
      end
      ACTIVE: begin
        if (slv_ready[sel_q]) begin
          cpl_ok  = 1'b1;
          state_d = RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt == TO_LAST) begin
          cpl_to  = 1'b1;
          state_d = RESP;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_q      <= '0;
      addr_q     <= '0;
      cnt        <= '0;
      pend_err   <= ERR_NONE;
      rv32_rdata <= '0;
      err_addr   <= '0;
    end else begin
      if (ld_req) begin
        sel_q    <= dec_sel;
        addr_q   <= rv32_addr;
        cnt      <= '0;
        pend_err <= miss ? ERR_UNMAPPED : ERR_NONE;
      end
      if (miss) begin
        rv32_rdata <= DEFAULT_RDATA;
        err_addr   <= rv32_addr;
      end
      if (inc_cnt && TIMEOUT_CYCLES != 0) cnt <= cnt + 1'b1;
      if (cpl_ok) rv32_rdata <= rdata_arr[sel_q];
      if (cpl_to) begin
        rv32_rdata <= DEFAULT_RDATA;
        pend_err   <= ERR_TIMEOUT;
        err_addr   <= addr_q;
      end
    end
  end

  // Handshake outputs decode straight from registered state, so they are glitch-free.
  always_comb begin
    slv_valid = '0;
    if (state == ACTIVE) slv_valid[sel_q] = 1'b1;
  end

  assign rv32_ready = (state == RESP);
  assign err_valid  = rv32_ready && (pend_err != ERR_NONE);
  assign err_code   = err_valid ? pend_err : ERR_NONE;
endmodule
